// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : useq_pkg
// Description : Shared definitions for the microsequencer: MIR field widths,
//               COND field encodings and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package useq_pkg;

    // MIR field widths shared with the microinstruction register
    localparam int c_ADDR_WIDTH = 11;
    localparam int c_COND_WIDTH = 3;
    localparam int c_OPC_WIDTH  = 8;

    // COND field encodings
    localparam logic [2:0] c_COND_NEXT   = 3'b000;
    localparam logic [2:0] c_COND_N      = 3'b001;
    localparam logic [2:0] c_COND_Z      = 3'b010;
    localparam logic [2:0] c_COND_V      = 3'b011;
    localparam logic [2:0] c_COND_C      = 3'b100;
    localparam logic [2:0] c_COND_IR13   = 3'b101;
    localparam logic [2:0] c_COND_DECODE = 3'b110;
    localparam logic [2:0] c_COND_JUMP   = 3'b111;

    // Sequencer state codes (also exported on the debug port)
    localparam logic [2:0] c_ST_START   = 3'd0;
    localparam logic [2:0] c_ST_RUN     = 3'd1;
    localparam logic [2:0] c_ST_MEMWAIT = 3'd2;
    localparam logic [2:0] c_ST_HALTED  = 3'd3;

endpackage : useq_pkg
`default_nettype wire

// File: rtl/useq_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : useq_next_addr
// Description : Combinational next-microaddress selector. Chooses between
//               uPC+1, the MIR jump address (conditionally on a PSR flag or
//               IR13) and the opcode-derived DECODE address.
// Ports       : i_cond      - MIR COND field
//               i_jump_addr - MIR JUMP_ADDR field
//               i_upc       - current uPC
//               i_n/i_z/i_v/i_c - PSR flags
//               i_ir13      - IR bit 13
//               i_opcode    - IR {op, op3}
//               o_next_addr - selected next address
// Revision    : 1.0 - initial release
// ============================================================================
module useq_next_addr
    import useq_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int COND_WIDTH = c_COND_WIDTH,
    parameter int OPC_WIDTH  = c_OPC_WIDTH
) (
    input  logic [COND_WIDTH-1:0] i_cond,
    input  logic [ADDR_WIDTH-1:0] i_jump_addr,
    input  logic [ADDR_WIDTH-1:0] i_upc,
    input  logic                  i_n,
    input  logic                  i_z,
    input  logic                  i_v,
    input  logic                  i_c,
    input  logic                  i_ir13,
    input  logic [OPC_WIDTH-1:0]  i_opcode,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    logic [ADDR_WIDTH-1:0] w_upc_inc;
    logic [ADDR_WIDTH-1:0] w_decode_addr;

    // Natural modulo wrap: the last control-store word rolls over to 0
    assign w_upc_inc     = i_upc + ADDR_WIDTH'(1);
    // Each opcode owns a 4-word slot in the upper half of the control store
    assign w_decode_addr = {1'b1, i_opcode, 2'b00};

    always_comb begin
        o_next_addr = w_upc_inc;
        case (i_cond)
            c_COND_NEXT:   o_next_addr = w_upc_inc;
            c_COND_N:      o_next_addr = i_n    ? i_jump_addr : w_upc_inc;
            c_COND_Z:      o_next_addr = i_z    ? i_jump_addr : w_upc_inc;
            c_COND_V:      o_next_addr = i_v    ? i_jump_addr : w_upc_inc;
            c_COND_C:      o_next_addr = i_c    ? i_jump_addr : w_upc_inc;
            c_COND_IR13:   o_next_addr = i_ir13 ? i_jump_addr : w_upc_inc;
            c_COND_DECODE: o_next_addr = w_decode_addr;
            c_COND_JUMP:   o_next_addr = i_jump_addr;
            default:       o_next_addr = w_upc_inc;
        endcase
    end

endmodule : useq_next_addr
`default_nettype wire

// File: rtl/useq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : useq_sequencer
// Description : Microsequencer. Owns the uPC, evaluates MIR branch fields,
//               stalls on memory microinstructions with a timeout trap, and
//               supports debug halt/resume.
// Ports       : USEQ_CLOCK_50        - clock, rising edge
//               SC_USEQ_Reset_InLow  - async active-low reset
//               USEQ_COND_IN / USEQ_JUMP_ADDR_IN / USEQ_RD_IN / USEQ_WR_IN
//                                    - MIR fields
//               USEQ_N/Z/V/C_IN      - PSR flags
//               USEQ_IR13_IN / USEQ_IR_OPCODE_IN - IR bits for branching
//               USEQ_MEM_READY_IN    - memory access complete
//               USEQ_HALT_IN         - debug halt request
//               USEQ_CS_ADDR_OUT     - registered uPC to control store
//               USEQ_MIR_LOAD_OUT    - MIR capture enable
//               USEQ_CWRITE_EN_OUT   - register-file write qualifier
//               USEQ_MEM_REQ_OUT     - memory request
//               USEQ_STALL_OUT       - uPC not advancing
//               USEQ_ERR_OUT         - sticky memory-timeout flag
//               USEQ_STATE_OUT       - debug state code
// Revision    : 1.0 - initial release
// ============================================================================
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int                   COND_WIDTH  = c_COND_WIDTH,
    parameter int                   OPC_WIDTH   = c_OPC_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = 11'h7F0,
    parameter int                   MEM_TIMEOUT = 15
) (
    input  logic                  USEQ_CLOCK_50,
    input  logic                  SC_USEQ_Reset_InLow,
    input  logic [COND_WIDTH-1:0] USEQ_COND_IN,
    input  logic [ADDR_WIDTH-1:0] USEQ_JUMP_ADDR_IN,
    input  logic                  USEQ_RD_IN,
    input  logic                  USEQ_WR_IN,
    input  logic                  USEQ_N_IN,
    input  logic                  USEQ_Z_IN,
    input  logic                  USEQ_V_IN,
    input  logic                  USEQ_C_IN,
    input  logic                  USEQ_IR13_IN,
    input  logic [OPC_WIDTH-1:0]  USEQ_IR_OPCODE_IN,
    input  logic                  USEQ_MEM_READY_IN,
    input  logic                  USEQ_HALT_IN,
    output logic [ADDR_WIDTH-1:0] USEQ_CS_ADDR_OUT,
    output logic                  USEQ_MIR_LOAD_OUT,
    output logic                  USEQ_CWRITE_EN_OUT,
    output logic                  USEQ_MEM_REQ_OUT,
    output logic                  USEQ_STALL_OUT,
    output logic                  USEQ_ERR_OUT,
    output logic [2:0]            USEQ_STATE_OUT
);

    localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_upc;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic                  r_err;

    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_upc_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_err_nxt;
    logic [ADDR_WIDTH-1:0] w_branch_addr;
    logic                  w_mir_load;
    logic                  w_cwrite_en;
    logic                  w_mem_req;
    logic                  w_stall;

    useq_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COND_WIDTH (COND_WIDTH),
        .OPC_WIDTH  (OPC_WIDTH)
    ) u_next_addr (
        .i_cond      (USEQ_COND_IN),
        .i_jump_addr (USEQ_JUMP_ADDR_IN),
        .i_upc       (r_upc),
        .i_n         (USEQ_N_IN),
        .i_z         (USEQ_Z_IN),
        .i_v         (USEQ_V_IN),
        .i_c         (USEQ_C_IN),
        .i_ir13      (USEQ_IR13_IN),
        .i_opcode    (USEQ_IR_OPCODE_IN),
        .o_next_addr (w_branch_addr)
    );

    always_ff @(posedge USEQ_CLOCK_50 or negedge SC_USEQ_Reset_InLow) begin
        if (!SC_USEQ_Reset_InLow) begin
            r_state    <= c_ST_START;
            r_upc      <= RESET_ADDR;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_upc      <= w_upc_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_cnt_nxt   = r_wait_cnt;
        w_err_nxt   = r_err;
        w_mir_load  = 1'b0;
        w_cwrite_en = 1'b0;
        w_mem_req   = 1'b0;
        w_stall     = 1'b1;

        if (!SC_USEQ_Reset_InLow) begin
            // Present START outputs while reset is held, independent of state
            w_mir_load = 1'b1;
        end else begin
            case (r_state)
                c_ST_START: begin
                    w_mir_load  = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (USEQ_HALT_IN) begin
                        // The held microinstruction is re-evaluated on resume
                        w_state_nxt = c_ST_HALTED;
                    end else if (USEQ_RD_IN || USEQ_WR_IN) begin
                        w_mem_req   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_MEMWAIT;
                    end else begin
                        w_upc_nxt   = w_branch_addr;
                        w_cwrite_en = 1'b1;
                        w_mir_load  = 1'b1;
                        w_stall     = 1'b0;
                    end
                end
                c_ST_MEMWAIT: begin
                    w_mem_req = 1'b1;
                    // Ready takes precedence over the timeout on the same cycle
                    if (USEQ_MEM_READY_IN) begin
                        w_upc_nxt   = w_branch_addr;
                        w_cwrite_en = 1'b1;
                        w_mir_load  = 1'b1;
                        w_stall     = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_RUN;
                    end else if (r_wait_cnt == c_CNT_W'(MEM_TIMEOUT)) begin
                        w_upc_nxt   = TRAP_ADDR;
                        w_err_nxt   = 1'b1;
                        w_mem_req   = 1'b0;
                        w_mir_load  = 1'b1;
                        w_stall     = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_HALTED: begin
                    if (!USEQ_HALT_IN) begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_START;
                end
            endcase
        end
    end

    assign USEQ_CS_ADDR_OUT   = r_upc;
    assign USEQ_MIR_LOAD_OUT  = w_mir_load;
    assign USEQ_CWRITE_EN_OUT = w_cwrite_en;
    assign USEQ_MEM_REQ_OUT   = w_mem_req;
    assign USEQ_STALL_OUT     = w_stall;
    assign USEQ_ERR_OUT       = r_err;
    assign USEQ_STATE_OUT     = r_state;

endmodule : useq_sequencer
`default_nettype wire

// File: tb/tb_useq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_useq_sequencer
// Description : Directed self-checking bench for useq_sequencer. The bench
//               plays the role of the MIR/PSR/IR and memory, steps the clock
//               and compares outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_useq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        rd, wr, n, z, v, c, ir13, ready, halt;
    logic [7:0]  opc;
    logic [10:0] cs_addr;
    logic        mir_load, cwrite_en, mem_req, stall, err;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    useq_sequencer dut (
        .USEQ_CLOCK_50       (clk),
        .SC_USEQ_Reset_InLow (rst_n),
        .USEQ_COND_IN        (cond),
        .USEQ_JUMP_ADDR_IN   (jump),
        .USEQ_RD_IN          (rd),
        .USEQ_WR_IN          (wr),
        .USEQ_N_IN           (n),
        .USEQ_Z_IN           (z),
        .USEQ_V_IN           (v),
        .USEQ_C_IN           (c),
        .USEQ_IR13_IN        (ir13),
        .USEQ_IR_OPCODE_IN   (opc),
        .USEQ_MEM_READY_IN   (ready),
        .USEQ_HALT_IN        (halt),
        .USEQ_CS_ADDR_OUT    (cs_addr),
        .USEQ_MIR_LOAD_OUT   (mir_load),
        .USEQ_CWRITE_EN_OUT  (cwrite_en),
        .USEQ_MEM_REQ_OUT    (mem_req),
        .USEQ_STALL_OUT      (stall),
        .USEQ_ERR_OUT        (err),
        .USEQ_STATE_OUT      (state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are then changed and outputs checked
    // 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump unconditionally to addr from a RUN cycle.
    task automatic goto_addr(input logic [10:0] addr);
        rd = 0; wr = 0; halt = 0; ready = 0;
        cond = 3'b111; jump = addr;
        step();
        cond = 3'b000;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; cond = 0; jump = 0; rd = 0; wr = 0; n = 0; z = 0; v = 0; c = 0;
        ir13 = 0; opc = 0; ready = 0; halt = 0;
        step(); step();
        n_vec++; if (cs_addr !== 11'd0) begin n_err++; $display("FAIL rst_cs_addr: got %h want %h", cs_addr, 11'd0); end
        n_vec++; if (mir_load !== 1'b1) begin n_err++; $display("FAIL rst_mir_load: got %b want 1", mir_load); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", stall); end
        n_vec++; if (cwrite_en !== 1'b0) begin n_err++; $display("FAIL rst_cwrite: got %b want 0", cwrite_en); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
        rst_n = 1;
        #1;
        // START cycle after release
        n_vec++; if (state !== 3'd0 || cwrite_en !== 1'b0 || mir_load !== 1'b1) begin
            n_err++; $display("FAIL start_cycle: state %0d cwrite %b mir_load %b want 0/0/1", state, cwrite_en, mir_load); end
        // RUN cycles: uPC 0,1,2,3 with CWRITE_EN high
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (cs_addr !== 11'(i) || cwrite_en !== 1'b1 || stall !== 1'b0) begin
                n_err++; $display("FAIL run_seq[%0d]: cs %h cwrite %b stall %b want %h/1/0", i, cs_addr, cwrite_en, stall, 11'(i)); end
        end
    endtask

    task automatic test_branch();
        goto_addr(11'd5);
        cond = 3'b010; jump = 11'h040; z = 1;
        step();
        n_vec++; if (cs_addr !== 11'h040) begin n_err++; $display("FAIL br_z_taken: got %h want 040", cs_addr); end
        goto_addr(11'd5);
        cond = 3'b010; jump = 11'h040; z = 0;
        step();
        n_vec++; if (cs_addr !== 11'h006) begin n_err++; $display("FAIL br_z_not: got %h want 006", cs_addr); end
        cond = 3'b110; opc = 8'h9A;
        step();
        n_vec++; if (cs_addr !== 11'h668) begin n_err++; $display("FAIL br_decode: got %h want 668", cs_addr); end
        // N taken, C not taken, IR13 taken, V taken
        goto_addr(11'd100);
        cond = 3'b001; n = 1; jump = 11'h123;
        step();
        n_vec++; if (cs_addr !== 11'h123) begin n_err++; $display("FAIL br_n_taken: got %h want 123", cs_addr); end
        cond = 3'b100; c = 0; jump = 11'h321;
        step();
        n_vec++; if (cs_addr !== 11'h124) begin n_err++; $display("FAIL br_c_not: got %h want 124", cs_addr); end
        cond = 3'b101; ir13 = 1; jump = 11'h200;
        step();
        n_vec++; if (cs_addr !== 11'h200) begin n_err++; $display("FAIL br_ir13: got %h want 200", cs_addr); end
        cond = 3'b011; v = 1; jump = 11'h055;
        step();
        n_vec++; if (cs_addr !== 11'h055) begin n_err++; $display("FAIL br_v_taken: got %h want 055", cs_addr); end
        cond = 0; n = 0; z = 0; v = 0; c = 0; ir13 = 0;
    endtask

    task automatic test_mem_read();
        goto_addr(11'd10);
        rd = 1;
        #1;
        n_vec++; if (stall !== 1 || mem_req !== 1 || cwrite_en !== 0) begin
            n_err++; $display("FAIL rd_issue: stall %b req %b cwrite %b want 1/1/0", stall, mem_req, cwrite_en); end
        for (int i = 1; i <= 3; i++) begin
            step();
            ready = (i == 3);
            #1;
            n_vec++; if (cs_addr !== 11'd10 || state !== 3'd2) begin
                n_err++; $display("FAIL rd_wait[%0d]: cs %h state %0d want 00a/2", i, cs_addr, state); end
            if (i < 3) begin
                n_vec++; if (stall !== 1 || mem_req !== 1 || cwrite_en !== 0) begin
                    n_err++; $display("FAIL rd_hold[%0d]: stall %b req %b cwrite %b want 1/1/0", i, stall, mem_req, cwrite_en); end
            end else begin
                n_vec++; if (cwrite_en !== 1 || stall !== 0 || mir_load !== 1) begin
                    n_err++; $display("FAIL rd_ready: cwrite %b stall %b mir %b want 1/0/1", cwrite_en, stall, mir_load); end
            end
        end
        step();
        rd = 0; ready = 0;
        #1;
        n_vec++; if (cs_addr !== 11'd11 || state !== 3'd1 || cwrite_en !== 1) begin
            n_err++; $display("FAIL rd_done: cs %h state %0d cwrite %b want 00b/1/1", cs_addr, state, cwrite_en); end
    endtask

    task automatic test_halt();
        goto_addr(11'd20);
        halt = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (cs_addr !== 11'd20 || cwrite_en !== 0 || stall !== 1) begin
                n_err++; $display("FAIL halt_hold[%0d]: cs %h cwrite %b stall %b want 014/0/1", i, cs_addr, cwrite_en, stall); end
            step();
        end
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL halt_state: got %0d want 3", state); end
        halt = 0;
        step();
        n_vec++; if (cs_addr !== 11'd20 || state !== 3'd1 || cwrite_en !== 1) begin
            n_err++; $display("FAIL halt_resume: cs %h state %0d cwrite %b want 014/1/1", cs_addr, state, cwrite_en); end
        step();
        n_vec++; if (cs_addr !== 11'd21) begin n_err++; $display("FAIL halt_next: got %h want 015", cs_addr); end
        // Halt raised during MEMWAIT is deferred until the access completes
        goto_addr(11'd40);
        rd = 1;
        step();
        halt = 1;
        #1;
        n_vec++; if (state !== 3'd2 || mem_req !== 1) begin
            n_err++; $display("FAIL halt_memwait: state %0d req %b want 2/1", state, mem_req); end
        ready = 1;
        #1;
        n_vec++; if (cwrite_en !== 1 || stall !== 0) begin
            n_err++; $display("FAIL halt_mem_ready: cwrite %b stall %b want 1/0", cwrite_en, stall); end
        step();
        ready = 0; rd = 0;
        #1;
        n_vec++; if (cs_addr !== 11'd41 || state !== 3'd1 || cwrite_en !== 0 || stall !== 1) begin
            n_err++; $display("FAIL halt_after_mem: cs %h state %0d cwrite %b stall %b want 029/1/0/1", cs_addr, state, cwrite_en, stall); end
        step();
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL halt_after_mem_state: got %0d want 3", state); end
        halt = 0;
        step();
    endtask

    task automatic test_back_to_back();
        goto_addr(11'd50);
        rd = 1;
        step();                    // MEMWAIT, counter 0
        for (int i = 0; i < 5; i++) step();
        ready = 1;
        step();                    // RUN at 51, next access still RD
        ready = 0;
        #1;
        n_vec++; if (cs_addr !== 11'd51 || mem_req !== 1 || stall !== 1) begin
            n_err++; $display("FAIL b2b_issue: cs %h req %b stall %b want 033/1/1", cs_addr, mem_req, stall); end
        step();                    // second access, counter restarts at 0
        // 15 non-ready wait cycles (counter 0..14) must not trap
        for (int i = 0; i < 15; i++) step();
        n_vec++; if (state !== 3'd2 || cs_addr !== 11'd51 || err !== 0) begin
            n_err++; $display("FAIL b2b_fresh_cnt: state %0d cs %h err %b want 2/033/0", state, cs_addr, err); end
        ready = 1;                 // ready on the timeout cycle wins
        step();
        ready = 0; rd = 0;
        #1;
        n_vec++; if (cs_addr !== 11'd52 || err !== 0 || state !== 3'd1) begin
            n_err++; $display("FAIL b2b_ready_wins: cs %h err %b state %0d want 034/0/1", cs_addr, err, state); end
    endtask

    task automatic test_wrap();
        goto_addr(11'h7FF);
        ready = 1;                 // stray ready outside MEMWAIT is ignored
        step();
        ready = 0;
        n_vec++; if (cs_addr !== 11'd0 || state !== 3'd1) begin
            n_err++; $display("FAIL wrap: cs %h state %0d want 000/1", cs_addr, state); end
    endtask

    task automatic test_timeout();
        goto_addr(11'd30);
        wr = 1;
        step();                    // MEMWAIT, counter 0
        for (int i = 0; i < 15; i++) begin
            n_vec++; if (state !== 3'd2 || mem_req !== 1) begin
                n_err++; $display("FAIL to_wait[%0d]: state %0d req %b want 2/1", i, state, mem_req); end
            step();
        end
        // Counter now equals the timeout: trap cycle
        n_vec++; if (mem_req !== 0 || mir_load !== 1 || cwrite_en !== 0) begin
            n_err++; $display("FAIL to_trap_cycle: req %b mir %b cwrite %b want 0/1/0", mem_req, mir_load, cwrite_en); end
        step();
        wr = 0;
        #1;
        n_vec++; if (cs_addr !== 11'h7F0 || err !== 1 || state !== 3'd1 || mem_req !== 0) begin
            n_err++; $display("FAIL to_trap: cs %h err %b state %0d req %b want 7f0/1/1/0", cs_addr, err, state, mem_req); end
        step(); step(); step();
        n_vec++; if (err !== 1) begin n_err++; $display("FAIL to_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_memwait();
        goto_addr(11'd60);
        rd = 1;
        step();
        n_vec++; if (mem_req !== 1 || state !== 3'd2) begin
            n_err++; $display("FAIL rmw_pre: req %b state %0d want 1/2", mem_req, state); end
        #2 rst_n = 0;              // mid-cycle, away from any clock edge
        #1;
        n_vec++; if (cs_addr !== 11'd0 || mem_req !== 0 || err !== 0 || state !== 3'd0) begin
            n_err++; $display("FAIL rmw_async: cs %h req %b err %b state %0d want 000/0/0/0", cs_addr, mem_req, err, state); end
        rd = 0;
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_mem_read();
        test_halt();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_reset_mid_memwait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_useq_sequencer
`default_nettype wire
